imem_arbiter: RTL and testbench

- Sequences and shares the single-port instruction memory between two requesters: the IF-stage fetch port (read-only) and the program loader/debug port (read/write).
- Converts byte addresses to word indices, runs a fixed-latency memory transaction counter and returns responses to the winning requester.
- Sits between the IF stage and the instruction memory array.
- Round-robin arbitration, one outstanding transaction, back-to-back issue allowed.

---
 rtl/imem_arbiter.sv | 87 ++++++++
 tb/tb_imem_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin sharing of a fixed-latency single-port instruction memory
// between the IF fetch port and the loader/debug port, one transaction outstanding.
module imem_arbiter #(
  parameter int MEM_AW      = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);
  typedef enum logic {S_IDLE, S_WAIT} state_e;
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       owner_q, owner_d, last_q, last_d, we_q, we_d;
  logic       resp, can_issue, f_win, l_win;
  logic       unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[31:MEM_AW+2], f_addr[1:0], l_addr[31:MEM_AW+2], l_addr[1:0]};
  // issue is gated by rst_n so every output reads 0 while reset is held
  always_comb begin
    resp      = (state_q == S_WAIT) && (cnt_q == LAT);
    can_issue = rst_n && ((state_q == S_IDLE) || resp);
    f_win     = can_issue && f_req && (!l_req || last_q);
    l_win     = can_issue && l_req && (!f_req || !last_q);
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    if (state_q == S_WAIT) begin
      cnt_d   = cnt_q + 4'd1;
      state_d = resp ? S_IDLE : S_WAIT;
    end
    if (f_win || l_win) begin
      state_d = S_WAIT;
      cnt_d   = 4'd1;
      owner_d = l_win;
      last_d  = l_win;
      we_d    = l_win && l_we;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
    end
  end
  assign f_gnt     = f_win;
  assign l_gnt     = l_win;
  assign f_stall   = rst_n && f_req && !f_win;
  assign mem_en    = f_win || l_win;
  assign mem_we    = l_win && l_we;
  assign mem_addr  = f_win ? f_addr[MEM_AW+1:2] : l_win ? l_addr[MEM_AW+1:2] : '0;
  assign mem_wdata = l_win ? l_wdata : 32'd0;
  assign f_rvalid  = resp && !owner_q;
  assign l_rvalid  = resp && owner_q;
  assign f_rdata   = f_rvalid ? mem_rdata : 32'd0;
  assign l_rdata   = (l_rvalid && !we_q) ? mem_rdata : 32'd0;
  assign busy      = (state_q == S_WAIT);
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: randomized and directed checks of imem_arbiter against a
// transaction-level model; a second instance covers the single-cycle-latency build.
module tb_imem_arbiter;
  localparam int LAT = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, f_req, f_gnt, f_rvalid, f_stall, l_req, l_we, l_gnt, l_rvalid;
  logic mem_en, mem_we, busy;
  logic [31:0] f_addr, f_rdata, l_addr, l_wdata, l_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  imem_arbiter #(.MEM_AW(16), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_stall(f_stall), .l_req(l_req),
    .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .l_rvalid(l_rvalid), .l_rdata(l_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  logic rst1_n, f_req1, f_gnt1, f_rvalid1, f_stall1, l_gnt1, l_rvalid1;
  logic mem_en1, mem_we1, busy1;
  logic [31:0] f_addr1, f_rdata1, l_rdata1, mem_wdata1, rd1;
  logic [15:0] mem_addr1;

  imem_arbiter #(.MEM_AW(16), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .f_req(f_req1), .f_addr(f_addr1), .f_gnt(f_gnt1),
    .f_rvalid(f_rvalid1), .f_rdata(f_rdata1), .f_stall(f_stall1), .l_req(1'b0),
    .l_we(1'b0), .l_addr(32'd0), .l_wdata(32'd0), .l_gnt(l_gnt1),
    .l_rvalid(l_rvalid1), .l_rdata(l_rdata1), .mem_en(mem_en1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(rd1), .busy(busy1)
  );

  int checks = 0, passes = 0;

  function automatic logic [31:0] h(input logic [15:0] i);
    return {i, ~i} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // memory device: serves whatever the DUT addresses, data appears LAT cycles after issue
  logic [31:0] mem_dev [0:65535];
  logic [31:0] mem_m   [0:65535];
  logic [31:0] pipe [0:15];
  assign mem_rdata = pipe[LAT-1];
  always @(posedge clk) begin
    for (int i = 15; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= (mem_en && !mem_we) ? mem_dev[mem_addr] : 32'hA5A5_A5A5;
    if (mem_en && mem_we) mem_dev[mem_addr] <= mem_wdata;
  end
  always @(posedge clk) if (mem_en1) rd1 <= h(mem_addr1);

  // transaction-level model: issue allowed once the previous response cycle is reached
  int cyc = 0, free_at = 0, pend_cyc = 0;
  bit last_l = 1'b1, pend = 1'b0, pend_l = 1'b0, m_fg = 1'b0, m_lg = 1'b0;
  logic [31:0] pend_data = 32'd0;

  always @(negedge clk) begin : model
    bit rsp, fw, lw, win_l, frv, lrv;
    logic [15:0] idx;
    if (!rst_n) begin
      chk("rst f_gnt", {31'd0, f_gnt}, 0);      chk("rst l_gnt", {31'd0, l_gnt}, 0);
      chk("rst f_stall", {31'd0, f_stall}, 0);  chk("rst mem_en", {31'd0, mem_en}, 0);
      chk("rst mem_we", {31'd0, mem_we}, 0);    chk("rst mem_addr", {16'd0, mem_addr}, 0);
      chk("rst mem_wdata", mem_wdata, 0);       chk("rst f_rvalid", {31'd0, f_rvalid}, 0);
      chk("rst f_rdata", f_rdata, 0);           chk("rst l_rvalid", {31'd0, l_rvalid}, 0);
      chk("rst l_rdata", l_rdata, 0);           chk("rst busy", {31'd0, busy}, 0);
      cyc = 0; free_at = 0; last_l = 1'b1; pend = 1'b0; m_fg = 1'b0; m_lg = 1'b0;
    end else begin
      rsp = pend && (cyc == pend_cyc);
      fw = 1'b0; lw = 1'b0;
      if (cyc >= free_at && (f_req || l_req)) begin
        win_l = (f_req && l_req) ? !last_l : l_req;
        fw = !win_l; lw = win_l;
      end
      frv = rsp && !pend_l;
      lrv = rsp && pend_l;
      idx = fw ? f_addr[17:2] : lw ? l_addr[17:2] : 16'd0;
      chk("f_gnt", {31'd0, f_gnt}, {31'd0, fw});
      chk("l_gnt", {31'd0, l_gnt}, {31'd0, lw});
      chk("f_stall", {31'd0, f_stall}, {31'd0, f_req && !fw});
      chk("mem_en", {31'd0, mem_en}, {31'd0, fw || lw});
      chk("mem_we", {31'd0, mem_we}, {31'd0, lw && l_we});
      chk("mem_addr", {16'd0, mem_addr}, {16'd0, idx});
      chk("mem_wdata", mem_wdata, lw ? l_wdata : 32'd0);
      chk("f_rvalid", {31'd0, f_rvalid}, {31'd0, frv});
      chk("f_rdata", f_rdata, frv ? pend_data : 32'd0);
      chk("l_rvalid", {31'd0, l_rvalid}, {31'd0, lrv});
      chk("l_rdata", l_rdata, lrv ? pend_data : 32'd0);
      chk("busy", {31'd0, busy}, {31'd0, pend});
      if (rsp) pend = 1'b0;
      if (fw || lw) begin
        pend = 1'b1; pend_cyc = cyc + LAT; pend_l = lw; free_at = cyc + LAT; last_l = lw;
        pend_data = (lw && l_we) ? 32'd0 : mem_m[idx];
        if (lw && l_we) mem_m[idx] = l_wdata;
      end
      m_fg = fw; m_lg = lw;
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] ra();
    return ($urandom & 32'hFFFC_0003) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    rst_n = 1'b0; f_req = 1'b0; f_addr = 32'd0; l_req = 1'b0; l_we = 1'b0;
    l_addr = 32'd0; l_wdata = 32'd0; rst1_n = 1'b0; f_req1 = 1'b0; f_addr1 = 32'd0;
    for (int i = 0; i < 16; i++) pipe[i] = 32'd0;
    for (int i = 0; i < 65536; i++) begin
      mem_dev[i] = h(16'(i)); mem_m[i] = h(16'(i));
    end
    mem_dev[3] = 32'h2402_0005; mem_m[3] = 32'h2402_0005;
    // single-cycle-latency build: continuous fetch stream
    step(); rst1_n = 1'b1; f_req1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("L1 f_gnt", {31'd0, f_gnt1}, 1);
      chk("L1 f_stall", {31'd0, f_stall1}, 0);
      if (k > 0) begin
        chk("L1 f_rvalid", {31'd0, f_rvalid1}, 1);
        chk("L1 f_rdata", f_rdata1, h(16'(k - 1)));
      end
      step(); f_addr1 = 32'(4 * (k + 1));
    end
    f_req1 = 1'b0;
    // single fetch of word 3
    step(); rst_n = 1'b1; f_req = 1'b1; f_addr = 32'h0C;
    @(negedge clk); chk("t1 gnt", {31'd0, f_gnt}, 1); chk("t1 addr", {16'd0, mem_addr}, 3);
    step(); f_req = 1'b0;
    step(); @(negedge clk);
    chk("t1 rvalid", {31'd0, f_rvalid}, 1); chk("t1 rdata", f_rdata, 32'h2402_0005);
    // back-to-back fetches 0x00, 0x04, 0x08
    step(); f_req = 1'b1; f_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t2 gnt", {31'd0, f_gnt}, 1);
      if (i > 0) chk("t2 rdata", f_rdata, h(16'(i - 1)));
      step(); f_addr = 32'(4 * (i + 1));
      @(negedge clk); chk("t2 stall", {31'd0, f_stall}, 1);
      step();
    end
    f_req = 1'b0;
    @(negedge clk); chk("t2 last rdata", f_rdata, h(16'd2));
    // loader write then fetch of the same word
    step(); l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t4 l_gnt", {31'd0, l_gnt}, 1); chk("t4 we", {31'd0, mem_we}, 1);
    chk("t4 addr", {16'd0, mem_addr}, 8);
    step(); l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 32'h20;
    step(); @(negedge clk);
    chk("t4 l_rvalid", {31'd0, l_rvalid}, 1); chk("t4 l_rdata", l_rdata, 0);
    chk("t4 f_gnt", {31'd0, f_gnt}, 1);
    step(); f_req = 1'b0;
    step(); @(negedge clk); chk("t4 f_rdata", f_rdata, 32'hDEAD_BEEF);
    // reset at cnt=1 of a fetch, then a tie
    step(); f_req = 1'b1; f_addr = 32'h4;
    @(negedge clk); chk("t5 gnt", {31'd0, f_gnt}, 1);
    step(); rst_n = 1'b0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h10;
    @(negedge clk); chk("t5 rst busy", {31'd0, busy}, 0); chk("t5 rst gnt", {31'd0, f_gnt}, 0);
    step(); rst_n = 1'b1;
    @(negedge clk); chk("t5 tie f", {31'd0, f_gnt}, 1); chk("t5 tie l", {31'd0, l_gnt}, 0);
    step(); f_addr = 32'h40;
    @(negedge clk); chk("t5 no stale rvalid", {31'd0, f_rvalid}, 0);
    step(); @(negedge clk);
    chk("t5 l_gnt", {31'd0, l_gnt}, 1); chk("t5 f_rdata", f_rdata, h(16'd1));
    step(); l_req = 1'b0;
    step(); @(negedge clk);
    chk("t5 f_gnt2", {31'd0, f_gnt}, 1); chk("t5 l_rdata", l_rdata, h(16'd4));
    step(); f_req = 1'b0;
    step(); step();
    // randomized traffic with occasional resets and request withdrawal
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n = ($urandom_range(0, 249) != 0);
      if (!f_req || m_fg) begin
        f_req = ($urandom_range(0, 9) < 6); f_addr = ra();
      end else if ($urandom_range(0, 19) == 0) f_req = 1'b0;
      if (!l_req || m_lg) begin
        l_req = ($urandom_range(0, 9) < 4); l_addr = ra();
        l_we = $urandom_range(0, 1) == 1; l_wdata = $urandom;
      end else if ($urandom_range(0, 19) == 0) l_req = 1'b0;
    end
    step(); rst_n = 1'b1; f_req = 1'b0; l_req = 1'b0;
    repeat (LAT + 3) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
